// File: rtl/fpga_prog_pkg.sv
// rtl/fpga_prog_pkg.sv - State encoding and default parameters for the FPGA programming controller
package fpga_prog_pkg;

  localparam int DEF_CHAIN_LEN  = 64;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_RST_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    FETCH,
    SHIFT,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/fpga_prog_clk_div.sv
// rtl/fpga_prog_clk_div.sv - prog_clk phase counter with low/high phase-end strobes
module prog_clk_div
  import fpga_prog_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic low_end,
  output logic high_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          at_last;

  assign at_last  = (cnt == LAST);
  assign low_end  = run && !phase && at_last;
  assign high_end = run && phase && at_last;

  // Idling parks the counter at the start of a low phase so every bit begins aligned.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || !run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (at_last) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fpga_prog_ctrl.sv
// rtl/fpga_prog_ctrl.sv - Scan-chain FPGA configuration sequencer with byte readback
module fpga_prog_ctrl
  import fpga_prog_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           cfg_valid,
  input  logic [7:0]                     cfg_data,
  output logic                           cfg_ready,
  output logic                           rb_valid,
  output logic [7:0]                     rb_data,
  input  logic                           rb_ready,
  output logic                           prog_clk,
  output logic                           prog_rst,
  output logic                           prog_en,
  output logic                           prog_data,
  input  logic                           prog_data_rb,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] LEN = BW'(CHAIN_LEN);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  state_t        state;
  logic [RW-1:0] rst_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rb_byte;
  logic [2:0]    bit_idx;
  logic [BW-1:0] bit_cnt_nxt;
  logic          last_bit;
  logic          low_end;
  logic          high_end;

  assign bit_cnt_nxt = bit_cnt + BW'(1);
  // A byte closes after 8 bits or early when the chain runs out (partial last byte).
  assign last_bit    = (bit_idx == 3'd7) || (bit_cnt_nxt == LEN);

  prog_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == SHIFT),
    .clear   (abort),
    .low_end (low_end),
    .high_end(high_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      shreg     <= '0;
      rb_byte   <= '0;
      bit_idx   <= '0;
      bit_cnt   <= '0;
      cfg_ready <= 1'b0;
      rb_valid  <= 1'b0;
      rb_data   <= '0;
      prog_clk  <= 1'b0;
      prog_rst  <= 1'b0;
      prog_en   <= 1'b0;
      prog_data <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      cfg_ready <= 1'b0;
      rb_valid  <= 1'b0;
      prog_clk  <= 1'b0;
      prog_rst  <= 1'b0;
      prog_en   <= 1'b0;
      prog_data <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RST;
            busy     <= 1'b1;
            prog_rst <= 1'b1;
            rst_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        RST: begin
          if (rst_cnt == RST_LAST) begin
            state     <= FETCH;
            prog_rst  <= 1'b0;
            prog_en   <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        FETCH: begin
          if (cfg_valid && cfg_ready) begin
            state     <= SHIFT;
            cfg_ready <= 1'b0;
            shreg     <= cfg_data;
            prog_data <= cfg_data[0];
            bit_idx   <= '0;
            rb_byte   <= '0;
          end
        end
        SHIFT: begin
          if (low_end) begin
            prog_clk         <= 1'b1;
            rb_byte[bit_idx] <= prog_data_rb;
          end
          if (high_end) begin
            prog_clk <= 1'b0;
            bit_cnt  <= bit_cnt_nxt;
            if (last_bit) begin
              state    <= DRAIN;
              rb_valid <= 1'b1;
              rb_data  <= rb_byte;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              prog_data <= shreg[bit_idx + 3'd1];
            end
          end
        end
        DRAIN: begin
          if (rb_ready) begin
            rb_valid <= 1'b0;
            if (bit_cnt == LEN) begin
              state   <= FINISH;
              prog_en <= 1'b0;
              done    <= 1'b1;
            end else begin
              state     <= FETCH;
              cfg_ready <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
